rcpu_ctrl: RTL
==============

// Module: rcpu_ctrl
// PURPOSE
//  Multi-cycle controller for the R-type CPU datapath: sequences PC, IR, A/B latches, ALU result latch and
//  register-file write port (Write_Reg/W_Addr) through FETCH-DECODE-EXEC-WB per instruction.
//  Decodes opcode/funct into ALU_OP; traps on illegal encodings. Sits beside the datapath, sole driver of its strobes.
// PARAMETERS
//  CNT_W     32   width of retired-instruction counter (RCTRL_STATS_EN only)
//  RUN_GATE  1    1: IDLE waits for run before each FETCH; 0: run sampled only once after reset
// PORTS
//  clk        in   1   rising-edge clock
//  rst        in   1   asynchronous, active-high reset
//  run        in   1   enable instruction sequencing
//  inst       in   32  IR contents (valid from DECODE onward)
//  PC_Write   out  1   PC <= PC+4 strobe
//  IR_Write   out  1   IR <= mem[PC] strobe
//  AB_Write   out  1   latch R_Data_A/R_Data_B into A/B
//  F_Write    out  1   latch ALU result into F
//  Write_Reg  out  1   register-file write enable
//  R_Addr_A   out  5   inst[25:21] (rs)
//  R_Addr_B   out  5   inst[20:16] (rt)
//  W_Addr     out  5   inst[15:11] (rd)
//  ALU_OP     out  3   ALU operation
//  busy       out  1   high in any state except IDLE/TRAP
//  trap       out  1   sticky illegal-instruction flag
//  retired    out  CNT_W  retired-instruction count (RCTRL_STATS_EN only)
// BEHAVIOUR
//  - Reset (async, any state, mid-instruction included): state IDLE; all strobes 0, ALU_OP 3'b000, trap 0,
//    retired 0; no partial register write ever issued after rst rises.
//  - Moore FSM, all strobes decoded from registered state (no comb. path inst->strobes except via latched ALU_OP):
//    IDLE  : no strobes; run=1 -> FETCH
//    FETCH : IR_Write=1, PC_Write=1 (exactly one cycle) -> DECODE
//    DECODE: AB_Write=1; register ALU_OP from funct; inst[31:26]!=0 or unknown funct -> TRAP, else -> EXEC
//    EXEC  : F_Write=1 -> WB
//    WB    : Write_Reg=1 iff rd!=0 and inst!=32'h0 -> FETCH if run=1 (or RUN_GATE=0), else IDLE
//    TRAP  : no strobes, trap=1, busy=0; exits only via rst
//  - Throughput: 4 cycles/instruction with run held high; run deassert only takes effect at WB (instruction completes).
//  - Funct map (opcode 0): 20 add->100, 22 sub->101, 24 and->000, 25 or->001, 26 xor->010, 27 nor->011,
//    2B sltu->110, 04 sllv->111. inst==32'h0 is NOP: legal, no write, counts as retired.
//  - ALU_OP held constant from DECODE+1 through WB; R_Addr_A/B, W_Addr are pure slices of inst.
//  - retired increments on WB exit, wraps modulo 2^CNT_W; trapped instructions not counted.
// CONFIGURATION
//  RCTRL_STATS_EN defined : retired counter present and driven as above.
//  RCTRL_STATS_EN undefined: retired port absent; no counter logic; all other behaviour identical.
// STRUCTURE
//  rcpu_pkg: state encodings (IDLE..TRAP), funct codes, ALU_OP codes.
//  Sub-module rcpu_funct_decode: combinational funct -> {ALU_OP, legal}; instanced once in rcpu_ctrl.
// TESTING
//  1 rst, run=1, inst=32'h00430820 (add $1,$2,$3) -> FETCH/DECODE/EXEC/WB strobes in 4 cycles,
//    ALU_OP=100, Write_Reg=1 with W_Addr=1 in WB only.
//  2 each of the 8 functs back-to-back -> correct ALU_OP each; period exactly 4 cycles; retired=8.
//  3 inst=32'h00000820 (rd=1, funct 20 with rs=rt=0) then 32'h0 -> first writes rd=1; NOP has Write_Reg=0, retired+1.
//  4 inst=32'h8C010000 (opcode 23) -> TRAP after DECODE, trap=1, no F_Write/Write_Reg, holds until rst.
//  5 rst pulsed during EXEC -> all strobes 0 same cycle, no Write_Reg, resumes from IDLE/FETCH after release.
//  6 run dropped during EXEC -> WB completes, then IDLE; run=1 again -> FETCH next cycle.

Source files
------------

// File: rtl/rcpu_pkg.sv
// Shared encodings for the R-type CPU controller: FSM states, funct codes and ALU operations.
package rcpu_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_DECODE,
      ST_EXEC,
      ST_WB,
      ST_TRAP
   } state_t;

   localparam logic [5:0] FN_ADD  = 6'h20;
   localparam logic [5:0] FN_SUB  = 6'h22;
   localparam logic [5:0] FN_AND  = 6'h24;
   localparam logic [5:0] FN_OR   = 6'h25;
   localparam logic [5:0] FN_XOR  = 6'h26;
   localparam logic [5:0] FN_NOR  = 6'h27;
   localparam logic [5:0] FN_SLTU = 6'h2B;
   localparam logic [5:0] FN_SLLV = 6'h04;

   localparam logic [2:0] ALU_AND  = 3'b000;
   localparam logic [2:0] ALU_OR   = 3'b001;
   localparam logic [2:0] ALU_XOR  = 3'b010;
   localparam logic [2:0] ALU_NOR  = 3'b011;
   localparam logic [2:0] ALU_ADD  = 3'b100;
   localparam logic [2:0] ALU_SUB  = 3'b101;
   localparam logic [2:0] ALU_SLTU = 3'b110;
   localparam logic [2:0] ALU_SLLV = 3'b111;

endpackage

// File: rtl/rcpu_ctrl_if.sv
// Datapath bus between the controller (master) and the R-type datapath (slave).
interface rcpu_ctrl_if;
   logic [31:0] inst;
   logic        PC_Write;
   logic        IR_Write;
   logic        AB_Write;
   logic        F_Write;
   logic        Write_Reg;
   logic [4:0]  R_Addr_A;
   logic [4:0]  R_Addr_B;
   logic [4:0]  W_Addr;
   logic [2:0]  ALU_OP;

   modport master (
      input  inst,
      output PC_Write, IR_Write, AB_Write, F_Write, Write_Reg,
      output R_Addr_A, R_Addr_B, W_Addr, ALU_OP
   );

   modport slave (
      output inst,
      input  PC_Write, IR_Write, AB_Write, F_Write, Write_Reg,
      input  R_Addr_A, R_Addr_B, W_Addr, ALU_OP
   );
endinterface

// File: rtl/rcpu_funct_decode.sv
// Combinational funct -> ALU operation decode; legal is low for any funct outside the supported set.
module rcpu_funct_decode
   import rcpu_pkg::*;
(
   input  logic [5:0] funct,
   output logic [2:0] alu_op,
   output logic       legal
);

   always_comb begin
      alu_op = ALU_AND;
      legal  = 1'b1;
      case (funct)
         FN_ADD:  alu_op = ALU_ADD;
         FN_SUB:  alu_op = ALU_SUB;
         FN_AND:  alu_op = ALU_AND;
         FN_OR:   alu_op = ALU_OR;
         FN_XOR:  alu_op = ALU_XOR;
         FN_NOR:  alu_op = ALU_NOR;
         FN_SLTU: alu_op = ALU_SLTU;
         FN_SLLV: alu_op = ALU_SLLV;
         default: legal  = 1'b0;
      endcase
   end

endmodule

// File: rtl/rcpu_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/WB controller for the R-type datapath.
// Optional retired-instruction counter enabled by defining RCTRL_STATS_EN.
module rcpu_ctrl
   import rcpu_pkg::*;
#(
   parameter bit RUN_GATE = 1'b1
`ifdef RCTRL_STATS_EN
   , parameter int unsigned CNT_W = 32
`endif
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        run,
   rcpu_ctrl_if.master bus,
   output logic        busy,
   output logic        trap
`ifdef RCTRL_STATS_EN
   , output logic [CNT_W-1:0] retired
`endif
);

   state_t      state, state_nxt;
   logic [2:0]  alu_op_q;
   logic        wr_en_q;
   logic [2:0]  dec_alu_op;
   logic        dec_legal;
   logic        inst_legal;
   logic        is_nop;

   rcpu_funct_decode u_funct_decode (
      .funct  (bus.inst[5:0]),
      .alu_op (dec_alu_op),
      .legal  (dec_legal)
   );

   assign is_nop     = (bus.inst == '0);
   assign inst_legal = is_nop || ((bus.inst[31:26] == '0) && dec_legal);

   assign bus.R_Addr_A = bus.inst[25:21];
   assign bus.R_Addr_B = bus.inst[20:16];
   assign bus.W_Addr   = bus.inst[15:11];
   assign bus.ALU_OP   = alu_op_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   // Write enable is captured at DECODE so Write_Reg in WB comes from registers only.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         alu_op_q <= ALU_AND;
         wr_en_q  <= 1'b0;
      end else if (state == ST_DECODE) begin
         alu_op_q <= dec_alu_op;
         wr_en_q  <= (bus.inst[15:11] != '0) && !is_nop;
      end
   end

   always_comb begin
      state_nxt     = state;
      bus.PC_Write  = 1'b0;
      bus.IR_Write  = 1'b0;
      bus.AB_Write  = 1'b0;
      bus.F_Write   = 1'b0;
      bus.Write_Reg = 1'b0;
      busy          = 1'b1;
      trap          = 1'b0;
      case (state)
         ST_IDLE: begin
            busy = 1'b0;
            if (run) state_nxt = ST_FETCH;
         end
         ST_FETCH: begin
            bus.IR_Write = 1'b1;
            bus.PC_Write = 1'b1;
            state_nxt    = ST_DECODE;
         end
         ST_DECODE: begin
            bus.AB_Write = 1'b1;
            state_nxt    = inst_legal ? ST_EXEC : ST_TRAP;
         end
         ST_EXEC: begin
            bus.F_Write = 1'b1;
            state_nxt   = ST_WB;
         end
         ST_WB: begin
            bus.Write_Reg = wr_en_q;
            state_nxt     = (run || !RUN_GATE) ? ST_FETCH : ST_IDLE;
         end
         ST_TRAP: begin
            busy = 1'b0;
            trap = 1'b1;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

`ifdef RCTRL_STATS_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                retired <= '0;
      else if (state == ST_WB) retired <= retired + CNT_W'(1);
   end
`endif

endmodule
